// File: rtl/core_pkg.sv
// Shared core definitions: PC-source encodings, fetch defaults and the
// fetch hold-FSM state encoding.
package core_pkg;

  // Next-PC select codes driven by the execute stage / hazard unit
  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  // Bubble instruction (addi x0,x0,0) and default reset vector
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // Hold FSM states
  localparam logic [0:0] HOLD_RUN  = 1'b0;
  localparam logic [0:0] HOLD_HOLD = 1'b1;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the synchronous BRAM.
interface fetch_stage_if #(
  parameter int IMEM_AW = 10
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;

  // Fetch side: presents the word address, receives data one cycle later
  modport master (output imem_addr, input imem_rdata);
  // Memory side
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fd_hold_buffer.sv
// Keeps Instr_D stable while decode is stalled: the BRAM keeps reading the
// next PC, so the instruction belonging to PC_D is captured on stall entry.
module fd_hold_buffer
  import core_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        Valid_D,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D
);

  logic [0:0]  state;
  logic [31:0] hold_instr;

  // RUN/HOLD state: hold while decode is stalled, flush always returns to RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HOLD_RUN;
    end else if (Flush_D || !Stall_D) begin
      state <= HOLD_RUN;
    end else begin
      state <= HOLD_HOLD;
    end
  end

  // Capture the BRAM word only on the stall-entry edge; later stall edges
  // would see the next sequential word instead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_instr <= '0;
    end else if (state == HOLD_RUN && Stall_D && !Flush_D) begin
      hold_instr <= imem_rdata;
    end
  end

  // Decode instruction select: bubble, held word, or live BRAM output
  always_comb begin
    Instr_D = imem_rdata;
    if (!Valid_D) begin
      Instr_D = NOP_INSTR;
    end else if (state == HOLD_HOLD) begin
      Instr_D = hold_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus F/D pipeline register. PC_F addresses a
// synchronous-read BRAM whose output lines up with PC_D one cycle later.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              IMEM_AW   = 10,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall_F,
  input  logic              Stall_D,
  input  logic              Flush_D,
  input  logic [1:0]        PC_Src_E,
  input  logic [XLEN-1:0]   PCTarget_E,
  input  logic [XLEN-1:0]   ALUResult_E,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   PC_F,
  output logic [31:0]       Instr_D,
  output logic [XLEN-1:0]   PC_D,
  output logic [XLEN-1:0]   PCPlus4_D,
  output logic              Valid_D
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_sel;
  logic [XLEN-1:0] pc_next;
  logic            redirect;

  assign pc_plus4       = PC_F + XLEN'(4);
  assign redirect       = (PC_Src_E != PC_SRC_PLUS4);
  assign imem.imem_addr = PC_F[IMEM_AW+1:2];

  // Next-PC mux; the reserved code falls back to sequential fetch and the
  // result is always word aligned
  always_comb begin
    pc_sel = pc_plus4;
    case (PC_Src_E)
      PC_SRC_BRANCH: pc_sel = PCTarget_E;
      PC_SRC_JALR:   pc_sel = ALUResult_E & ~XLEN'(1);
      default:       pc_sel = pc_plus4;
    endcase
    pc_next = pc_sel & ~XLEN'(3);
  end

  // PC register: a redirect from execute overrides a fetch stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_F <= RESET_PC;
    end else if (redirect || !Stall_F) begin
      PC_F <= pc_next;
    end
  end

  // F/D register: flush beats stall; the instruction word itself comes from
  // the BRAM output (or the hold buffer) rather than being registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (Flush_D) begin
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (!Stall_D) begin
      PC_D      <= PC_F;
      PCPlus4_D <= pc_plus4;
      Valid_D   <= 1'b1;
    end
  end

  fd_hold_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .Stall_D    (Stall_D),
    .Flush_D    (Flush_D),
    .Valid_D    (Valid_D),
    .imem_rdata (imem.imem_rdata),
    .Instr_D    (Instr_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous BRAM model holding
// mem[i] = 32'h1000_0000 + i and a queue of expected post-edge values.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        Stall_F;
  logic        Stall_D;
  logic        Flush_D;
  logic [1:0]  PC_Src_E;
  logic [31:0] PCTarget_E;
  logic [31:0] ALUResult_E;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        Valid_D;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        vld;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:1023];

  fetch_stage_if #(.IMEM_AW(10)) imem ();

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .IMEM_AW   (10),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Flush_D     (Flush_D),
    .PC_Src_E    (PC_Src_E),
    .PCTarget_E  (PCTarget_E),
    .ALUResult_E (ALUResult_E),
    .imem        (imem.master),
    .PC_F        (PC_F),
    .Instr_D     (Instr_D),
    .PC_D        (PC_D),
    .PCPlus4_D   (PCPlus4_D),
    .Valid_D     (Valid_D)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read instruction memory
  always_ff @(posedge clk) begin
    imem.imem_rdata <= mem[imem.imem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".PC_F"},      PC_F,                   e.pcf);
    chk({tag, ".imem_addr"}, {22'b0, imem.imem_addr}, {22'b0, e.pcf[11:2]});
    chk({tag, ".PC_D"},      PC_D,                   e.pcd);
    chk({tag, ".PCPlus4_D"}, PCPlus4_D,              e.pc4);
    chk({tag, ".Valid_D"},   {31'b0, Valid_D},       {31'b0, e.vld});
    chk({tag, ".Instr_D"},   Instr_D,                e.instr);
  endtask

  // One clock edge: queue expectations, drive inputs, compare after the edge
  task automatic step(input string tag, input logic sf, input logic sd, input logic fl,
                      input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                      input logic ev, input logic [31:0] epcd, input logic [31:0] einstr,
                      input logic [31:0] epcf);
    exp_t e;
    e.pcf   = epcf;
    e.pcd   = epcd;
    e.pc4   = ev ? epcd + 32'd4 : 32'd0;
    e.instr = ev ? einstr : 32'h0000_0013;
    e.vld   = ev;
    sb.push_back(e);
    Stall_F     = sf;
    Stall_D     = sd;
    Flush_D     = fl;
    PC_Src_E    = src;
    PCTarget_E  = tgt;
    ALUResult_E = alu;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  initial begin
    exp_t r;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    r.pcf = 32'h0; r.pcd = 32'h0; r.pc4 = 32'h0; r.instr = 32'h0000_0013; r.vld = 1'b0;

    reset = 1'b0; Stall_F = 0; Stall_D = 0; Flush_D = 0;
    PC_Src_E = 2'b00; PCTarget_E = '0; ALUResult_E = '0;
    #2;
    chk_all("reset0", r);
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset_clocked", r);
    reset = 1'b1;

    // Sequential fetch after reset
    step("run0", 0,0,0, 2'b00, 0, 0, 1, 32'h0,  32'h1000_0000, 32'h4);
    step("run1", 0,0,0, 2'b00, 0, 0, 1, 32'h4,  32'h1000_0001, 32'h8);
    step("run2", 0,0,0, 2'b00, 0, 0, 1, 32'h8,  32'h1000_0002, 32'hC);
    // Three-cycle stall at PC_D = 8
    step("stall0", 1,1,0, 2'b00, 0, 0, 1, 32'h8, 32'h1000_0002, 32'hC);
    step("stall1", 1,1,0, 2'b00, 0, 0, 1, 32'h8, 32'h1000_0002, 32'hC);
    step("stall2", 1,1,0, 2'b00, 0, 0, 1, 32'h8, 32'h1000_0002, 32'hC);
    step("unstall", 0,0,0, 2'b00, 0, 0, 1, 32'hC,  32'h1000_0003, 32'h10);
    step("run3",    0,0,0, 2'b00, 0, 0, 1, 32'h10, 32'h1000_0004, 32'h14);
    // Branch to 0x40 with two bubbles
    step("flush0",  0,0,1, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h18);
    step("br_fl1",  0,0,1, 2'b01, 32'h40, 0, 0, 32'h0, 32'h0, 32'h40);
    step("br_tgt",  0,0,0, 2'b00, 0, 0, 1, 32'h40, 32'h1000_0010, 32'h44);
    // JALR target 0x25 aligns to 0x24
    step("jalr",    0,0,0, 2'b10, 32'h80, 32'h25, 1, 32'h44, 32'h1000_0011, 32'h24);
    step("jalr_t",  0,0,0, 2'b00, 0, 0, 1, 32'h24, 32'h1000_0009, 32'h28);
    // Reserved select behaves as PC+4
    step("rsvd",    0,0,0, 2'b11, 32'h80, 32'h100, 1, 32'h28, 32'h1000_000A, 32'h2C);
    // Stall into HOLD, then stall+flush together
    step("hold",    1,1,0, 2'b00, 0, 0, 1, 32'h28, 32'h1000_000A, 32'h2C);
    step("st_fl",   1,1,1, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h2C);
    step("post_fl", 0,0,0, 2'b00, 0, 0, 1, 32'h2C, 32'h1000_000B, 32'h30);
    step("run4",    0,0,0, 2'b00, 0, 0, 1, 32'h30, 32'h1000_000C, 32'h34);
    // Redirect while decode stalled
    step("st_redir", 1,1,0, 2'b01, 32'h100, 0, 1, 32'h30, 32'h1000_000C, 32'h100);
    step("st_rfl",   0,0,1, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h104);
    step("redir_r",  0,0,0, 2'b00, 0, 0, 1, 32'h104, 32'h1000_0041, 32'h108);
    // PC wrap-around at the top of the address space
    step("to_top",  0,0,0, 2'b01, 32'hFFFF_FFFC, 0, 1, 32'h108, 32'h1000_0042, 32'hFFFF_FFFC);
    step("wrap",    0,0,0, 2'b00, 0, 0, 1, 32'hFFFF_FFFC, 32'h1000_03FF, 32'h0);
    step("wrap2",   0,0,0, 2'b00, 0, 0, 1, 32'h0, 32'h1000_0000, 32'h4);
    // Asynchronous reset in the middle of a stall
    step("pre_rst", 1,1,0, 2'b00, 0, 0, 1, 32'h0, 32'h1000_0000, 32'h4);
    #3 reset = 1'b0;
    #1;
    chk_all("async_rst", r);
    #1;
    reset = 1'b1;
    step("after_rst", 0,0,0, 2'b00, 0, 0, 1, 32'h0, 32'h1000_0000, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
